// File: rtl/id_imm_ctrl.sv
// id_imm_ctrl: two-entry skid buffer between instruction fetch and decode.
// Each accepted instruction is stored with its decoded immediate type. The
// presented (main) entry drives a single ImmGen instance, so the immediate is
// available combinationally alongside id_valid.
// if_ready comes straight from a register, so id_ready has no combinational
// path back to the fetch side.
// Optional feature macro: IMM_CSR_IMM_EN. When it is defined, CSR immediate
// forms (opcode 1110011 with inst[14]=1) decode to CSR_IMM.

package CorePack;
  typedef enum logic [2:0] {
    IMM0    = 3'd0,
    I_IMM   = 3'd1,
    S_IMM   = 3'd2,
    B_IMM   = 3'd3,
    U_IMM   = 3'd4,
    UJ_IMM  = 3'd5,
    CSR_IMM = 3'd6
  } imm_op_enum;
endpackage

// ImmGen: expands the immediate field of an RV64 instruction for the given type.
module ImmGen (
  input  logic [31:0]          inst,
  input  CorePack::imm_op_enum imm_op,
  output logic [63:0]          imm
);
  import CorePack::*;

  // Select and sign-extend the immediate bits for each instruction format.
  always_comb begin
    imm = '0;
    case (imm_op)
      I_IMM:   imm = {{52{inst[31]}}, inst[31:20]};
      S_IMM:   imm = {{52{inst[31]}}, inst[31:25], inst[11:7]};
      B_IMM:   imm = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      U_IMM:   imm = {{32{inst[31]}}, inst[31:12], 12'b0};
      UJ_IMM:  imm = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      CSR_IMM: imm = {59'b0, inst[19:15]};
      default: imm = '0;
    endcase
  end
endmodule

module id_imm_ctrl (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 if_valid,
  input  logic [31:0]          if_inst,
  input  logic [63:0]          if_pc,
  output logic                 if_ready,
  input  logic                 flush,
  output logic                 id_valid,
  input  logic                 id_ready,
  output logic [31:0]          id_inst,
  output logic [63:0]          id_pc,
  output CorePack::imm_op_enum id_imm_op,
  output logic [63:0]          id_imm
);
  import CorePack::*;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t     state;
  logic       id_valid_q;
  logic       if_ready_q;

  logic [31:0] main_inst;
  logic [63:0] main_pc;
  imm_op_enum  main_op;
  logic [31:0] skid_inst;
  logic [63:0] skid_pc;
  imm_op_enum  skid_op;

  imm_op_enum  in_op;
  logic        in_xfer;
  logic        out_xfer;

  assign in_xfer  = if_valid && if_ready_q;
  assign out_xfer = id_valid_q && id_ready;

  // Decode the immediate type of the incoming instruction from its opcode.
  always_comb begin
    in_op = IMM0;
    case (if_inst[6:0])
      7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011: in_op = I_IMM;
      7'b0100011: in_op = S_IMM;
      7'b1100011: in_op = B_IMM;
      7'b0110111, 7'b0010111: in_op = U_IMM;
      7'b1101111: in_op = UJ_IMM;
`ifdef IMM_CSR_IMM_EN
      7'b1110011: in_op = if_inst[14] ? CSR_IMM : IMM0;
`else
      7'b1110011: in_op = IMM0;
`endif
      default: in_op = IMM0;
    endcase
  end

  // Buffer state machine: main entry is what is presented, skid catches one extra.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= EMPTY;
      id_valid_q <= 1'b0;
      if_ready_q <= 1'b1;
      main_inst  <= '0;
      main_pc    <= '0;
      main_op    <= IMM0;
      skid_inst  <= '0;
      skid_pc    <= '0;
      skid_op    <= IMM0;
    end else if (flush) begin
      state      <= EMPTY;
      id_valid_q <= 1'b0;
      if_ready_q <= 1'b1;
      main_inst  <= '0;
      main_pc    <= '0;
      main_op    <= IMM0;
      skid_inst  <= '0;
      skid_pc    <= '0;
      skid_op    <= IMM0;
    end else begin
      case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_inst  <= if_inst;
            main_pc    <= if_pc;
            main_op    <= in_op;
            id_valid_q <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_inst <= if_inst;
            main_pc   <= if_pc;
            main_op   <= in_op;
          end else if (in_xfer) begin
            skid_inst  <= if_inst;
            skid_pc    <= if_pc;
            skid_op    <= in_op;
            if_ready_q <= 1'b0;
            state      <= FULL;
          end else if (out_xfer) begin
            main_inst  <= '0;
            main_pc    <= '0;
            main_op    <= IMM0;
            id_valid_q <= 1'b0;
            state      <= EMPTY;
          end
        end
        FULL: begin
          if (out_xfer) begin
            main_inst  <= skid_inst;
            main_pc    <= skid_pc;
            main_op    <= skid_op;
            skid_inst  <= '0;
            skid_pc    <= '0;
            skid_op    <= IMM0;
            if_ready_q <= 1'b1;
            state      <= ONE;
          end
        end
        default: begin
          state      <= EMPTY;
          id_valid_q <= 1'b0;
          if_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign if_ready  = if_ready_q;
  assign id_valid  = id_valid_q;
  assign id_inst   = main_inst;
  assign id_pc     = main_pc;
  assign id_imm_op = main_op;

  ImmGen u_imm_gen (
    .inst   (main_inst),
    .imm_op (main_op),
    .imm    (id_imm)
  );
endmodule
